fpu_vec_sequencer: RTL and testbench
====================================

Name: fpu_vec_sequencer

Overview:
Initiator side of the FPU operand/result interface. It accepts one vector operation (LANES element pairs plus an opcode) from the vector datapath and issues the elements to the scalar FPU one at a time. For each element it raises enable, holds the operands until ready, captures O, then drops enable for one cycle. It sits between the vector execute stage and the FPU and returns the assembled result vector with a done pulse.

Parameters:
LANES, 4, elements per vector operation (≥1)
W, 32, element width (IEEE-754 single)
TIMEOUT, 64, maximum WAIT cycles per element before abort

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
start  in  1  request pulse; sampled only in IDLE
op  in  2  FPU opcode for the whole vector
vec_a  in  LANES*W  operand A; lane i = bits [i*W +: W]
vec_b  in  LANES*W  operand B, same packing
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
err  out  1  timeout abort flag; valid with done
result  out  LANES*W  result vector; stable from done until the next accepted start
fpu_enable  out  1  to FPU enable
fpu_A  out  W  to FPU A
fpu_B  out  W  to FPU B
fpu_opcode  out  2  to FPU opcode
fpu_ready  in  1  from FPU ready
fpu_O  in  W  from FPU O

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, err, fpu_enable = 0; result, fpu_A, fpu_B, fpu_opcode, lane index and watchdog count = 0. Reset mid-vector abandons the operation with no done pulse.
- IDLE: if start=1, latch vec_a, vec_b and op; idx=0; clear err; go to ISSUE. Any start while not in IDLE is ignored.
- ISSUE (1 cycle): fpu_A=a[idx], fpu_B=b[idx], fpu_opcode=op, fpu_enable=1. Go to WAIT.
- WAIT: fpu_enable and operands held constant.
  - fpu_ready=1 at a rising edge: result lane idx ← fpu_O; go to GAP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT: err=1, result lane idx ← 0, go to DONE. Remaining lanes keep their previous values.
- GAP (1 cycle): fpu_enable=0 so the FPU clears its internal state. Watchdog=0. If idx==LANES-1 go to DONE; otherwise idx+1 and go to ISSUE.
- DONE (1 cycle): done=1, busy=0. Next state IDLE. A start in the DONE cycle is ignored.
- fpu_ready is ignored outside WAIT. If ready is seen in the first WAIT cycle, per-element latency is 3 cycles.
- Total latency, start to done = 1 + Σ(2 + Ri) + 1, where Ri = WAIT cycles for lane i (Ri ≥ 1).
- Opcodes are passed through unmodified: 00 add, 01 sub, 10 div (multi-cycle), 11 mul.

Optional Feature:
Macro: FPU_SEQ_TIMEOUT_EN
- Defined: watchdog counter and err behaviour as above.
- Undefined: no counter; WAIT waits indefinitely for fpu_ready; err is tied to 0; the TIMEOUT parameter is unused.

Decomposition:
- Package fpu_pkg holds:
  - fpu_op_t enum: FOP_ADD=2'b00, FOP_SUB=2'b01, FOP_DIV=2'b10, FOP_MUL=2'b11
  - seq_state_t enum: IDLE, ISSUE, WAIT, GAP, DONE
  - FP_W=32
- No sub-module. The watchdog is an inline counter guarded by the macro.

Test Plan:
- Bench uses a behavioural FPU model with programmable ready latency L.
- ADD, LANES=4, L=1, all lanes A=0x41500000 (13.0), B=0x428C0000 (70.0) -> every result lane 0x42A60000 (83.0); done exactly 14 cycles after start; fpu_enable low for exactly one cycle between elements.
- MUL, lane0 A=0x41700000 (15.0), B=0xC2500000 (-52.0) -> result lane0 0xC4430000 (-780.0); fpu_opcode=2'b11 throughout.
- DIV, L=15, A=0x40C00000 (6.0), B=0x40000000 (2.0) on all lanes -> lanes 0x40400000 (3.0); fpu_A and fpu_B stable for all WAIT cycles.
- Start pulsed while busy -> ignored; latched operands unchanged; exactly one done pulse.
- FPU_SEQ_TIMEOUT_EN defined, TIMEOUT=8, model never readies lane2 -> done with err=1 after 8 WAIT cycles; lane2=0; lanes 0-1 hold valid results.
- reset=0 during WAIT of lane1 -> fpu_enable, busy and result drop to 0 immediately; no done pulse; next start runs normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared types for the vector-to-scalar FPU sequencer.
//   FP_W        : default element width (IEEE-754 single precision)
//   fpu_op_t    : FPU opcode encoding, passed straight through to the FPU
//   seq_state_t : sequencer FSM states
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        FOP_ADD = 2'b00,
        FOP_SUB = 2'b01,
        FOP_DIV = 2'b10,
        FOP_MUL = 2'b11
    } fpu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fpu_vec_sequencer_if.sv
// ----------------------------------------------------------------------------
// fpu_vec_sequencer_if
// Operand/result handshake between the vector sequencer (master) and the
// scalar FPU (slave).
//   fpu_enable : master -> FPU, high while an element is being worked on
//   fpu_A/B    : master -> FPU, operands, held while fpu_enable is high
//   fpu_opcode : master -> FPU, operation select
//   fpu_ready  : FPU -> master, result on fpu_O is valid
//   fpu_O      : FPU -> master, result element
// ----------------------------------------------------------------------------
interface fpu_vec_sequencer_if #(
    parameter int W = 32
);
    logic         fpu_enable;
    logic [W-1:0] fpu_A;
    logic [W-1:0] fpu_B;
    logic [1:0]   fpu_opcode;
    logic         fpu_ready;
    logic [W-1:0] fpu_O;

    modport master (
        output fpu_enable,
        output fpu_A,
        output fpu_B,
        output fpu_opcode,
        input  fpu_ready,
        input  fpu_O
    );

    modport slave (
        input  fpu_enable,
        input  fpu_A,
        input  fpu_B,
        input  fpu_opcode,
        output fpu_ready,
        output fpu_O
    );
endinterface

// File: rtl/fpu_vec_sequencer.sv
// ----------------------------------------------------------------------------
// fpu_vec_sequencer
// Accepts one vector operation (LANES operand pairs + opcode) and feeds the
// elements to a scalar FPU one at a time: ISSUE raises enable, WAIT holds the
// operands until fpu_ready, GAP drops enable for one cycle so the FPU clears,
// and DONE pulses done with the assembled result vector.
//
// Ports:
//   CLK        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : request pulse, sampled only in IDLE
//   op         : opcode applied to every element
//   vec_a/b    : operand vectors, lane i at [i*W +: W]
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle completion pulse
//   err        : watchdog abort flag, valid with done
//   result     : result vector, stable from done until the next start
//   fpu        : FPU handshake (master modport)
//
// Build option: FPU_SEQ_TIMEOUT_EN
//   defined   -> per-element watchdog; after TIMEOUT WAIT cycles the vector is
//                aborted with err=1 and the stalled lane forced to zero
//   undefined -> WAIT waits forever for fpu_ready, err is tied low and
//                TIMEOUT is unused
// ----------------------------------------------------------------------------
module fpu_vec_sequencer
    import fpu_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int W       = FP_W,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [LANES*W-1:0]  vec_a,
    input  logic [LANES*W-1:0]  vec_b,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [LANES*W-1:0]  result,
    fpu_vec_sequencer_if.master fpu
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    seq_state_t           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LANES*W-1:0]   aVec_q, aVec_d;
    logic [LANES*W-1:0]   bVec_q, bVec_d;
    fpu_op_t              op_q, op_d;
    logic [LANES*W-1:0]   result_q, result_d;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 err_q, err_d;
`else
    logic                 unusedTimeout;
    assign unusedTimeout = (TIMEOUT == 0);
`endif

    // Next-state logic. Operands are latched once on start so the vector
    // inputs may change freely while the elements are being issued.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        aVec_d   = aVec_q;
        bVec_d   = bVec_q;
        op_d     = op_q;
        result_d = result_q;
`ifdef FPU_SEQ_TIMEOUT_EN
        wdog_d   = wdog_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    aVec_d  = vec_a;
                    bVec_d  = vec_b;
                    op_d    = fpu_op_t'(op);
                    idx_d   = '0;
`ifdef FPU_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
                    wdog_d  = '0;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (fpu.fpu_ready) begin
                    result_d[idx_q*W +: W] = fpu.fpu_O;
                    state_d = GAP;
                end
`ifdef FPU_SEQ_TIMEOUT_EN
                // The stalled lane is zeroed; lanes not yet reached keep
                // whatever the previous vector left there.
                else if (wdog_q == WDOG_LAST) begin
                    result_d[idx_q*W +: W] = '0;
                    err_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = DONE;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`endif
            end
            GAP: begin
`ifdef FPU_SEQ_TIMEOUT_EN
                wdog_d = '0;
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; an asynchronous reset abandons any vector in flight.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            aVec_q   <= '0;
            bVec_q   <= '0;
            op_q     <= FOP_ADD;
            result_q <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
            wdog_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            aVec_q   <= aVec_d;
            bVec_q   <= bVec_d;
            op_q     <= op_d;
            result_q <= result_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            wdog_q   <= wdog_d;
            err_q    <= err_d;
`endif
        end
    end

    // Outputs decode straight from registered state, so the operands seen by
    // the FPU cannot move while enable is high: idx only advances in GAP.
    assign busy           = (state_q == ISSUE) || (state_q == WAIT) || (state_q == GAP);
    assign done           = (state_q == DONE);
    assign result         = result_q;
    assign fpu.fpu_enable = (state_q == ISSUE) || (state_q == WAIT);
    assign fpu.fpu_A      = aVec_q[idx_q*W +: W];
    assign fpu.fpu_B      = bVec_q[idx_q*W +: W];
    assign fpu.fpu_opcode = op_q;

`ifdef FPU_SEQ_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_vec_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fpu_vec_sequencer
// Directed bench for fpu_vec_sequencer. A behavioural FPU answers each
// element after a programmable number of WAIT cycles and computes the result
// with real arithmetic; any element whose A operand equals STALL_A is never
// answered. Expected results and latencies are hand-computed constants.
// The watchdog sequence only runs when FPU_SEQ_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_fpu_vec_sequencer;
    import fpu_pkg::*;

    localparam int LANES  = 4;
    localparam int W      = 32;
    localparam int VW     = LANES * W;
    localparam int BUDGET = 400;
    localparam logic [31:0] STALL_A = 32'h47C35000;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        int            lat;
        logic [VW-1:0] expRes;
        int            expLat;
        bit            injectStart;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [1:0]    op;
    logic [VW-1:0] vecA;
    logic [VW-1:0] vecB;
    logic          busy;
    logic          done;
    logic          err;
    logic [VW-1:0] result;

    int            modelLat = 1;
    int            modelCnt = 0;
    int            checkCount = 0;
    int            passCount = 0;

    int            runLat;
    int            runDone;
    int            runGapBad;
    int            runOpBad;
    int            runUnstable;
    int            runIssues;
    logic          runErr;
    logic [VW-1:0] runRes;
    logic          runBusyAfter;
    logic          runTimedOut;

    vec_t          vecs[4];

    fpu_vec_sequencer_if #(.W(W)) fpuBus();

    fpu_vec_sequencer #(
        .LANES   (LANES),
        .W       (W),
        .TIMEOUT (8)
    ) dut (
        .CLK    (clk),
        .reset  (rstN),
        .start  (start),
        .op     (op),
        .vec_a  (vecA),
        .vec_b  (vecB),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .fpu    (fpuBus.master)
    );

    always #5 clk = ~clk;

    // Single-precision <-> real conversion for normal numbers and zero.
    function automatic real sp2real(input logic [31:0] s);
        logic [63:0] d;
        logic [10:0] e;
        if (s[30:0] == 31'd0) begin
            d = {s[31], 63'd0};
        end else begin
            e = {3'd0, s[30:23]} - 11'd127 + 11'd1023;
            d = {s[31], e, s[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        real ra;
        real rb;
        real rr;
        ra = sp2real(a);
        rb = sp2real(b);
        case (o)
            2'b00:   rr = ra + rb;
            2'b01:   rr = ra - rb;
            2'b10:   rr = (rb == 0.0) ? 0.0 : ra / rb;
            default: rr = ra * rb;
        endcase
        return real2sp(rr);
    endfunction

    // Behavioural FPU: counts cycles of enable, answers once the count
    // reaches modelLat (so modelLat equals the number of WAIT cycles).
    always @(posedge clk) begin
        if (!fpuBus.fpu_enable) modelCnt <= 0;
        else                    modelCnt <= modelCnt + 1;
    end

    always_comb begin
        fpuBus.fpu_ready = fpuBus.fpu_enable && (modelCnt >= modelLat) && (fpuBus.fpu_A != STALL_A);
        fpuBus.fpu_O     = fpModel(fpuBus.fpu_opcode, fpuBus.fpu_A, fpuBus.fpu_B);
    end

    task automatic checkOutput(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Runs one vector and records what was observed. Latency counts the
    // start cycle and the done cycle inclusively.
    task automatic applyStimulus(input vec_t v);
        int           edges;
        int           lowRun;
        logic         prevEn;
        logic [W-1:0] prevA;
        logic [W-1:0] prevB;
        modelLat     = v.lat;
        runLat       = 0;
        runDone      = 0;
        runGapBad    = 0;
        runOpBad     = 0;
        runUnstable  = 0;
        runIssues    = 0;
        runErr       = 1'b0;
        runRes       = '0;
        runBusyAfter = 1'b0;
        runTimedOut  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        vecA  = v.a;
        vecB  = v.b;
        @(negedge clk);
        start  = 1'b0;
        op     = ~v.op;
        vecA   = ~v.a;
        vecB   = ~v.b;
        edges  = 1;
        lowRun = 0;
        prevEn = 1'b0;
        prevA  = '0;
        prevB  = '0;
        forever begin
            if (runLat != 0 && edges == runLat) begin
                runBusyAfter = busy;
                start = 1'b0;
                break;
            end
            if (edges >= BUDGET) begin
                runTimedOut = 1'b1;
                start = 1'b0;
                break;
            end
            if (done) begin
                runDone++;
                if (runLat == 0) begin
                    runLat = edges + 1;
                    runErr = err;
                    runRes = result;
                    if (v.injectStart) begin
                        start = 1'b1;
                        vecA  = {LANES{32'h3F800000}};
                    end
                end
            end
            if (fpuBus.fpu_enable) begin
                if (!prevEn) runIssues++;
                else if (fpuBus.fpu_A != prevA || fpuBus.fpu_B != prevB) runUnstable++;
                if (fpuBus.fpu_opcode != v.op) runOpBad++;
            end
            if (busy && !fpuBus.fpu_enable) begin
                lowRun++;
            end else begin
                if (lowRun > 1) runGapBad++;
                lowRun = 0;
            end
            prevEn = fpuBus.fpu_enable;
            prevA  = fpuBus.fpu_A;
            prevB  = fpuBus.fpu_B;
            if (v.injectStart && edges == 5) begin
                start = 1'b1;
                vecA  = {LANES{32'h3F800000}};
                vecB  = {LANES{32'h3F800000}};
            end
            if (v.injectStart && edges == 6) start = 1'b0;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic checkRun(input vec_t v, input int expIssues, input logic expErr);
        checkOutput({v.name, " finished"}, VW'(runTimedOut), VW'(0));
        checkOutput({v.name, " result"}, runRes, v.expRes);
        checkOutput({v.name, " latency"}, VW'(runLat), VW'(v.expLat));
        checkOutput({v.name, " done pulses"}, VW'(runDone), VW'(1));
        checkOutput({v.name, " err"}, VW'(runErr), VW'(expErr));
        checkOutput({v.name, " enable gap"}, VW'(runGapBad), VW'(0));
        checkOutput({v.name, " opcode"}, VW'(runOpBad), VW'(0));
        checkOutput({v.name, " operand hold"}, VW'(runUnstable), VW'(0));
        checkOutput({v.name, " issues"}, VW'(runIssues), VW'(expIssues));
        checkOutput({v.name, " idle after done"}, VW'(runBusyAfter), VW'(0));
    endtask

    initial begin
        int   doneSeen;
        vec_t tv;

        vecs[0] = '{"add", FOP_ADD, {4{32'h41500000}}, {4{32'h428C0000}}, 1,
                    {4{32'h42A60000}}, 14, 1'b0};
        vecs[1] = '{"mul", FOP_MUL,
                    {32'h40000000, 32'h40000000, 32'h40000000, 32'h41700000},
                    {32'h40400000, 32'h40400000, 32'h40400000, 32'hC2500000}, 1,
                    {32'h40C00000, 32'h40C00000, 32'h40C00000, 32'hC4430000}, 14, 1'b0};
        vecs[2] = '{"div", FOP_DIV, {4{32'h40C00000}}, {4{32'h40000000}}, 15,
                    {4{32'h40400000}}, 70, 1'b0};
        vecs[3] = '{"sub busy-start", FOP_SUB, {4{32'h428C0000}}, {4{32'h41500000}}, 2,
                    {4{32'h42640000}}, 18, 1'b1};

        rstN  = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        vecA  = '0;
        vecB  = '0;

        @(negedge clk);
        checkOutput("reset busy", VW'(busy), VW'(0));
        checkOutput("reset done", VW'(done), VW'(0));
        checkOutput("reset err", VW'(err), VW'(0));
        checkOutput("reset enable", VW'(fpuBus.fpu_enable), VW'(0));
        checkOutput("reset result", result, '0);
        checkOutput("reset fpu_A", VW'(fpuBus.fpu_A), VW'(0));
        checkOutput("reset fpu_B", VW'(fpuBus.fpu_B), VW'(0));
        checkOutput("reset opcode", VW'(fpuBus.fpu_opcode), VW'(0));
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            checkRun(vecs[i], LANES, 1'b0);
        end

        // Reset while lane 1 of a slow divide is waiting.
        modelLat = 15;
        @(negedge clk);
        start = 1'b1;
        op    = FOP_DIV;
        vecA  = {4{32'h40C00000}};
        vecB  = {4{32'h40000000}};
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        checkOutput("pre-reset enable", VW'(fpuBus.fpu_enable), VW'(1));
        checkOutput("pre-reset lane0", VW'(result[31:0]), VW'(32'h40400000));
        rstN = 1'b0;
        #1;
        checkOutput("mid reset enable", VW'(fpuBus.fpu_enable), VW'(0));
        checkOutput("mid reset busy", VW'(busy), VW'(0));
        checkOutput("mid reset result", result, '0);
        doneSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        rstN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("mid reset no done", VW'(doneSeen), VW'(0));
        tv = vecs[0];
        tv.name = "add after reset";
        applyStimulus(tv);
        checkRun(tv, LANES, 1'b0);

`ifdef FPU_SEQ_TIMEOUT_EN
        // Lane 2 is never answered; lane 3 keeps the previous vector's value.
        tv = '{"timeout", FOP_MUL,
               {32'h40000000, STALL_A, 32'h40000000, 32'h40000000},
               {4{32'h40400000}}, 1,
               {32'h42A60000, 32'h00000000, 32'h40C00000, 32'h40C00000}, 17, 1'b0};
        applyStimulus(tv);
        checkRun(tv, 3, 1'b1);
        tv = vecs[1];
        tv.name = "mul after timeout";
        applyStimulus(tv);
        checkRun(tv, LANES, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
